multi_channel_capture: RTL and testbench

Parametrised N-channel triggered capture buffer that replaces the per-channel ring buffers and persistent-trigger logic with a single block. All ADC channels are written in lock-step into a circular store. On trigger, a fixed number of post-trigger samples is captured, then the frame freezes. One selected channel is then streamed out, oldest sample first, over a valid/ready port to the CC, FFT or UART consumer.

---
 rtl/multi_channel_capture.sv | 191 +++++++++++++++++++
 tb/tb_multi_channel_capture.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_capture.sv
// multi_channel_capture
// N-channel triggered capture buffer. All channels are written in lock-step
// into one circular store. A trigger with enough pre-trigger history starts a
// fixed-length post-trigger capture, after which the frame freezes. One
// selected channel is then streamed out, oldest sample first, on a
// valid/ready port.
// Build option: define MCC_TRIG_COUNT_EN to enable the saturating
// accepted-trigger counter; otherwise trig_count is tied to zero.
module multi_channel_capture #(
    parameter int NUM_CH    = 4,
    parameter int SAMPLE_W  = 10,
    parameter int DEPTH     = 256,
    parameter int POST_TRIG = 192,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       reset_b,
    input  logic [NUM_CH*SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    input  logic                       arm,
    input  logic                       trigger,
    input  logic [CH_W-1:0]            rd_ch,
    input  logic                       rd_start,
    input  logic                       rd_ready,
    output logic [SAMPLE_W-1:0]        rd_data,
    output logic                       rd_valid,
    output logic                       rd_last,
    output logic [1:0]                 state,
    output logic                       trig_missed,
    output logic [15:0]                trig_count
);

    localparam int AW    = $clog2(DEPTH);
    localparam int WW    = NUM_CH * SAMPLE_W;
    localparam int SEL_N = 1 << CH_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ARMED  = 2'd1;
    localparam logic [1:0] S_POST   = 2'd2;
    localparam logic [1:0] S_FROZEN = 2'd3;

    localparam logic [AW:0]   FILL_MIN  = (AW+1)'(DEPTH - POST_TRIG);
    localparam logic [AW:0]   FILL_MAX  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   POST_LAST = (AW+1)'(POST_TRIG);
    localparam logic [AW:0]   ONE_F     = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_P     = AW'(1);

    // Frame store: never reset, registered read.
    logic [WW-1:0]       mem [0:DEPTH-1];
    logic [WW-1:0]       mem_q;

    logic [1:0]          state_reg, state_next;
    logic [AW-1:0]       wr_ptr_reg, frame_start_reg, rd_ptr_reg, rd_addr;
    logic [AW:0]         fill_reg, post_cnt_reg, fetch_left_reg, fill_after;
    logic                trig_missed_reg;
    logic [CH_W-1:0]     rd_ch_reg;
    logic [SAMPLE_W-1:0] rd_data_reg;
    logic                rd_valid_reg, rd_last_reg;
    logic                wr_en, arm_ok, trig_ok, frame_done, rd_start_ok, rd_busy, load;

    // Channel lanes of the word just read; selector codes beyond NUM_CH alias channel 0.
    logic [SAMPLE_W-1:0] ch_word [SEL_N];
    genvar gi;
    for (gi = 0; gi < SEL_N; gi++) begin : g_lane
        if (gi < NUM_CH) begin : g_real
            assign ch_word[gi] = mem_q[gi*SAMPLE_W +: SAMPLE_W];
        end else begin : g_alias
            assign ch_word[gi] = mem_q[SAMPLE_W-1:0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) state_reg <= S_IDLE;
        else          state_reg <= state_next;
    end

    // Next-state logic; arm restarts a capture except while a readout is in flight.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:   if (arm) state_next = S_ARMED;
            S_ARMED:  if (arm) state_next = S_ARMED;
                      else if (trig_ok) state_next = S_POST;
            S_POST:   if (arm) state_next = S_ARMED;
                      else if (frame_done) state_next = S_FROZEN;
            S_FROZEN: if (arm_ok) state_next = S_ARMED;
            default:  state_next = S_IDLE;
        endcase
    end

    // Control strobes; a same-cycle sample is written before the trigger fill test.
    always_comb begin
        rd_busy     = (fetch_left_reg != '0) || rd_valid_reg;
        arm_ok      = arm && !((state_reg == S_FROZEN) && rd_busy);
        wr_en       = sample_valid && !arm && ((state_reg == S_ARMED) || (state_reg == S_POST));
        fill_after  = (wr_en && (fill_reg != FILL_MAX)) ? fill_reg + ONE_F : fill_reg;
        trig_ok     = (state_reg == S_ARMED) && !arm && trigger && (fill_after >= FILL_MIN);
        frame_done  = (state_reg == S_POST) && wr_en && ((post_cnt_reg + ONE_F) == POST_LAST);
        rd_start_ok = rd_start && (state_reg == S_FROZEN) && !rd_busy && !arm_ok;
        load        = (fetch_left_reg != '0) && (!rd_valid_reg || rd_ready);
        // Read address runs one word ahead so mem_q always holds the next word to present.
        if (rd_start_ok)  rd_addr = frame_start_reg;
        else if (load)    rd_addr = rd_ptr_reg + ONE_P;
        else              rd_addr = rd_ptr_reg;
    end

    // Capture pointers, fill level, post-trigger count and missed-trigger flag.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wr_ptr_reg      <= '0;
            fill_reg        <= '0;
            post_cnt_reg    <= '0;
            frame_start_reg <= '0;
            trig_missed_reg <= 1'b0;
        end else if (arm_ok) begin
            wr_ptr_reg      <= '0;
            fill_reg        <= '0;
            post_cnt_reg    <= '0;
            trig_missed_reg <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + ONE_P;
                fill_reg   <= fill_after;
                if (state_reg == S_POST) post_cnt_reg <= post_cnt_reg + ONE_F;
            end
            if (trig_ok)    post_cnt_reg    <= '0;
            if (frame_done) frame_start_reg <= wr_ptr_reg + ONE_P;
            if (trigger && ((state_reg == S_POST) || (state_reg == S_FROZEN)))
                trig_missed_reg <= 1'b1;
        end
    end

    // Frame store write port and registered read port.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_reg] <= sample_in;
        mem_q <= mem[rd_addr];
    end

    // Readout: fetch counter plus a single output register that holds under backpressure.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            rd_ch_reg      <= '0;
            rd_ptr_reg     <= '0;
            fetch_left_reg <= '0;
            rd_data_reg    <= '0;
            rd_valid_reg   <= 1'b0;
            rd_last_reg    <= 1'b0;
        end else begin
            if (rd_start_ok) begin
                rd_ch_reg      <= rd_ch;
                rd_ptr_reg     <= frame_start_reg;
                fetch_left_reg <= FILL_MAX;
            end else if (load) begin
                rd_ptr_reg     <= rd_ptr_reg + ONE_P;
                fetch_left_reg <= fetch_left_reg - ONE_F;
            end
            if (load) begin
                rd_data_reg  <= ch_word[rd_ch_reg];
                rd_valid_reg <= 1'b1;
                rd_last_reg  <= (fetch_left_reg == ONE_F);
            end else if (rd_valid_reg && rd_ready) begin
                rd_valid_reg <= 1'b0;
                rd_last_reg  <= 1'b0;
            end
        end
    end

`ifdef MCC_TRIG_COUNT_EN
    logic [15:0] trig_count_reg;

    // Accepted-trigger counter, saturating, cleared only by reset.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b)
            trig_count_reg <= '0;
        else if (trig_ok && (trig_count_reg != 16'hFFFF))
            trig_count_reg <= trig_count_reg + 16'd1;
    end

    assign trig_count = trig_count_reg;
`else
    assign trig_count = '0;
`endif

    assign state       = state_reg;
    assign trig_missed = trig_missed_reg;
    assign rd_data     = rd_data_reg;
    assign rd_valid    = rd_valid_reg;
    assign rd_last     = rd_last_reg;

endmodule

// File: tb/tb_multi_channel_capture.sv
// Testbench for multi_channel_capture: directed scenarios plus randomized
// captures, checked against a history-based reference model (the frame is
// simply the last DEPTH samples written since arm).
`timescale 1ns/1ps
module tb_multi_channel_capture;

    localparam int NUM_CH    = 4;
    localparam int SAMPLE_W  = 10;
    localparam int DEPTH     = 16;
    localparam int POST_TRIG = 8;
    localparam int WW        = NUM_CH * SAMPLE_W;

    logic              clk = 1'b0;
    logic              reset_b = 1'b0;
    logic [WW-1:0]     sample_in = '0;
    logic              sample_valid = 1'b0;
    logic              arm = 1'b0;
    logic              trigger = 1'b0;
    logic [1:0]        rd_ch = '0;
    logic              rd_start = 1'b0;
    logic              rd_ready = 1'b0;
    logic [SAMPLE_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_last;
    logic [1:0]        state;
    logic              trig_missed;
    logic [15:0]       trig_count;

    multi_channel_capture #(
        .NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH), .POST_TRIG(POST_TRIG)
    ) dut (
        .clk(clk), .reset_b(reset_b), .sample_in(sample_in), .sample_valid(sample_valid),
        .arm(arm), .trigger(trigger), .rd_ch(rd_ch), .rd_start(rd_start), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .state(state),
        .trig_missed(trig_missed), .trig_count(trig_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: capture state, write history since arm, flags.
    int          m_state = 0;
    logic [WW-1:0] m_hist[$];
    int          m_post = 0;
    bit          m_missed = 1'b0;
    int          m_tcount = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_count();
`ifdef MCC_TRIG_COUNT_EN
        return (m_tcount > 65535) ? 65535 : m_tcount;
`else
        return 0;
`endif
    endfunction

    function automatic logic [WW-1:0] pat(input int n);
        logic [WW-1:0] w;
        for (int c = 0; c < NUM_CH; c++) w[c*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(n*4 + c);
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic m_reset();
        m_state = 0; m_hist.delete(); m_post = 0; m_missed = 1'b0; m_tcount = 0;
    endtask

    // One clock of capture behaviour, with the state held at the start of the cycle.
    task automatic m_cycle(input bit sv, input logic [WW-1:0] w, input bit tg);
        int s;
        s = m_state;
        if (tg && (s == 2 || s == 3)) m_missed = 1'b1;
        if (sv && (s == 1 || s == 2)) m_hist.push_back(w);
        if (s == 1 && tg && m_hist.size() >= DEPTH - POST_TRIG) begin
            m_state = 2; m_post = 0; m_tcount++;
        end
        if (s == 2 && sv) begin
            m_post++;
            if (m_post == POST_TRIG) m_state = 3;
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_state"}, 32'(state), 32'(m_state));
        check({tag, "_missed"}, 32'(trig_missed), 32'(m_missed));
        check({tag, "_count"}, 32'(trig_count), 32'(exp_count()));
        check({tag, "_novalid"}, 32'(rd_valid), 32'd0);
    endtask

    task automatic drive(input bit sv, input logic [WW-1:0] w, input bit tg);
        sample_valid = sv; sample_in = w; trigger = tg;
        step();
        sample_valid = 1'b0; trigger = 1'b0;
        m_cycle(sv, w, tg);
        check("cyc_state", 32'(state), 32'(m_state));
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
        m_state = 1; m_hist.delete(); m_post = 0; m_missed = 1'b0;
        check_status("arm");
    endtask

    // Random capture until the model freezes (bounded).
    task automatic cap_random();
        int guard;
        logic [WW-1:0] w;
        guard = 0;
        while (m_state != 3 && guard < 400) begin
            w = WW'({$urandom(), $urandom()});
            drive($urandom_range(0, 2) != 0, w, $urandom_range(0, 5) == 0);
            guard++;
        end
        check("cap_frozen", 32'(state), 32'd3);
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0, 2: random ready.
    task automatic readout(input int ch, input int mode, input int stop_at, input bit arm_mid);
        logic [SAMPLE_W-1:0] exp_w [DEPTH];
        logic [WW-1:0] w;
        logic [SAMPLE_W-1:0] prev_d;
        bit prev_last, prev_stall, rdy;
        int got, cyc;
        for (int i = 0; i < DEPTH; i++) begin
            w = m_hist[m_hist.size() - DEPTH + i];
            exp_w[i] = w[ch*SAMPLE_W +: SAMPLE_W];
        end
        rd_ch = 2'(ch); rd_start = 1'b1; rd_ready = 1'b0;
        step();
        rd_start = 1'b0;
        check("lat_t1_valid", 32'(rd_valid), 32'd0);
        step();
        check("lat_t2_valid", 32'(rd_valid), 32'd1);
        got = 0; cyc = 0; prev_stall = 1'b0; prev_d = '0; prev_last = 1'b0;
        while (got < stop_at && cyc < 200) begin
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = (cyc % 3 == 0);
            else                rdy = 1'($urandom_range(0, 1));
            if (prev_stall) begin
                check("hold_valid", 32'(rd_valid), 32'd1);
                check("hold_data", 32'(rd_data), 32'(prev_d));
                check("hold_last", 32'(rd_last), 32'(prev_last));
            end
            arm = arm_mid && (cyc == 4);
            rd_ready = rdy;
            if (rd_valid && rdy) begin
                check($sformatf("rd_data[%0d]", got), 32'(rd_data), 32'(exp_w[got]));
                check($sformatf("rd_last[%0d]", got), 32'(rd_last), 32'(got == DEPTH - 1));
                got++;
            end
            prev_stall = rd_valid && !rdy; prev_d = rd_data; prev_last = rd_last;
            step();
            cyc++;
        end
        arm = 1'b0;
        rd_ready = 1'b0;
        check("rd_words", 32'(got), 32'(stop_at));
        if (stop_at == DEPTH) begin
            check("rd_end_valid", 32'(rd_valid), 32'd0);
            check("rd_end_state", 32'(state), 32'(m_state));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        // Reset state.
        step(); step();
        check("rst_state", 32'(state), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_last", 32'(rd_last), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);
        check("rst_missed", 32'(trig_missed), 32'd0);
        check("rst_count", 32'(trig_count), 32'd0);
        reset_b = 1'b1;
        step();
        check_status("idle");

        // Basic capture: trigger with strobe n=19, readout ch2 then re-read with backpressure.
        pulse_arm();
        for (int n = 0; n < 30; n++) drive(1'b1, pat(n), n == 19);
        check_status("basic");
        check("basic_frozen", 32'(state), 32'd3);
        readout(2, 0, DEPTH, 1'b0);
        readout(1, 1, DEPTH, 1'b1);
        check_status("reread");

        // Early triggers (fill 5, fill 7) ignored; trigger with strobe 8 accepted.
        pulse_arm();
        rd_start = 1'b1; drive(1'b0, '0, 1'b0); rd_start = 1'b0;
        drive(1'b0, '0, 1'b0); drive(1'b0, '0, 1'b0);
        check_status("rdstart_ignored");
        for (int n = 0; n < 5; n++) drive(1'b1, pat(n), 1'b0);
        drive(1'b0, '0, 1'b1);
        check_status("early5");
        for (int n = 5; n < 7; n++) drive(1'b1, pat(n), 1'b0);
        drive(1'b0, '0, 1'b1);
        check_status("early7");
        drive(1'b1, pat(7), 1'b1);
        check_status("accept8");
        // Missed trigger in POST.
        drive(1'b1, pat(8), 1'b0);
        drive(1'b0, '0, 1'b1);
        check_status("missed");
        for (int n = 9; n < 20; n++) drive(1'b1, pat(n), 1'b0);
        check_status("frozen2");
        readout($urandom_range(0, 3), 2, DEPTH, 1'b0);
        pulse_arm();

        // Randomized captures.
        for (int it = 0; it < 6; it++) begin
            cap_random();
            check_status($sformatf("rand%0d", it));
            readout($urandom_range(0, 3), 2, DEPTH, it[0]);
            pulse_arm();
        end

        // Reset mid-readout after word 5.
        cap_random();
        readout(3, 0, 5, 1'b0);
        rd_ready = 1'b1;
        reset_b = 1'b0;
        #1;
        check("rstmid_valid", 32'(rd_valid), 32'd0);
        check("rstmid_last", 32'(rd_last), 32'd0);
        check("rstmid_data", 32'(rd_data), 32'd0);
        check("rstmid_state", 32'(state), 32'd0);
        step();
        rd_ready = 1'b0;
        check("rstmid_state2", 32'(state), 32'd0);
        check("rstmid_count", 32'(trig_count), 32'd0);
        reset_b = 1'b1;
        m_reset();
        drive(1'b1, pat(0), 1'b1);
        check_status("post_rst");

        // Counter: three full captures after reset.
        for (int k = 0; k < 3; k++) begin
            pulse_arm();
            cap_random();
        end
        check("count3", 32'(trig_count), 32'(exp_count()));
        check_status("final");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
